// File: rtl/writeback_pkg.sv
// writeback_pkg: shared constants and types for the register-file writeback path.
//   REG_COUNT  - number of architectural integer registers
//   REG_ADDR_W - register address width
//   wb_src_e   - arbitration grant (which source owns the write port this cycle)
package writeback_pkg;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;
endpackage

// File: rtl/writeback_if.sv
// writeback_if: bundles the ALU/load result handshakes, the decode issue and
// scoreboard query signals, and the registered regfile write port.
//   master - the pipeline side (drives results, issue, queries; observes ready/busy/write port)
//   slave  - writeback_ctrl
interface writeback_if
  import writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] rd;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, rs1_q, rs2_q,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy, write_enable, rd, rd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, rs1_q, rs2_q,
    output alu_ready, mem_ready, rs1_busy, rs2_busy, write_enable, rd, rd_data
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard: one pending bit per architectural register.
//   clk, rst          - clock, synchronous active-high reset (clears all bits)
//   set_en/set_addr   - decode issued a write to set_addr
//   clr_en/clr_addr   - the write port is committing clr_addr this cycle
//   rs1_q/rs2_q       - query addresses; rs1_busy/rs2_busy - their pending bits
// Register 0 never becomes pending. When the same register is set and cleared at
// one edge the set wins, so a re-issue during the commit cycle keeps it busy.
module writeback_scoreboard
  import writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_q,
  input  logic [REG_ADDR_W-1:0] rs2_q,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // No forwarding: busy stays high through the commit cycle itself.
  assign rs1_busy = pending[rs1_q];
  assign rs2_busy = pending[rs2_q];

  // Decode may only re-issue a pending register in the cycle that commits it.
  a_issue_not_pending: assert property (@(posedge clk) disable iff (rst)
    !(set_en && (set_addr != '0) && pending[set_addr] &&
      !(clr_en && (clr_addr == set_addr))));
endmodule

// File: rtl/writeback_ctrl.sv
// writeback_ctrl: arbitrates ALU and load results onto the single regfile write
// port, one commit per cycle, with a round-robin flip after contested cycles.
//   clk, rst - clock, synchronous active-high reset
//   bus      - writeback_if.slave: result handshakes, issue/query, write port
// Optional feature macro: WRITEBACK_SCOREBOARD_EN builds the pending-bit
// scoreboard; without it rs1_busy/rs2_busy are tied 0 and issue_* is ignored.
module writeback_ctrl
  import writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 32
)(
  input  logic       clk,
  input  logic       rst,
  writeback_if.slave bus
);
  logic                  prio_mem;
  logic                  alu_rdy;
  logic                  mem_rdy;
  logic                  accept;
  logic                  contested;
  wb_src_e               grant;
  logic [REG_ADDR_W-1:0] acc_rd;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  we_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  assign alu_rdy   = ~(bus.mem_valid & prio_mem);
  assign mem_rdy   = ~(bus.alu_valid & ~prio_mem);
  assign contested = bus.alu_valid & bus.mem_valid;

  always_comb begin
    accept = 1'b0;
    grant  = WB_SRC_ALU;
    if (bus.alu_valid && alu_rdy) begin
      accept = 1'b1;
    end else if (bus.mem_valid && mem_rdy) begin
      accept = 1'b1;
      grant  = WB_SRC_MEM;
    end
    acc_rd   = (grant == WB_SRC_MEM) ? bus.mem_rd   : bus.alu_rd;
    acc_data = (grant == WB_SRC_MEM) ? bus.mem_data : bus.alu_data;
  end

  // Stage p1: registered write port. rd==0 results are consumed without a write
  // and leave rd/rd_data holding the last committed value.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_mem <= 1'b0;
      we_p1    <= 1'b0;
      rd_p1    <= '0;
      data_p1  <= '0;
    end else begin
      if (contested) prio_mem <= (grant == WB_SRC_ALU);
      we_p1 <= accept && (acc_rd != '0);
      if (accept && (acc_rd != '0)) begin
        rd_p1   <= acc_rd;
        data_p1 <= acc_data;
      end
    end
  end

  assign bus.alu_ready    = alu_rdy;
  assign bus.mem_ready    = mem_rdy;
  assign bus.write_enable = we_p1;
  assign bus.rd           = rd_p1;
  assign bus.rd_data      = data_p1;

`ifdef WRITEBACK_SCOREBOARD_EN
  writeback_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (bus.issue_valid),
    .set_addr (bus.issue_rd),
    .clr_en   (we_p1),
    .clr_addr (rd_p1),
    .rs1_q    (bus.rs1_q),
    .rs2_q    (bus.rs2_q),
    .rs1_busy (bus.rs1_busy),
    .rs2_busy (bus.rs2_busy)
  );
`else
  logic unused_sb;
  assign unused_sb    = ^{bus.issue_valid, bus.issue_rd, bus.rs1_q, bus.rs2_q};
  assign bus.rs1_busy = 1'b0;
  assign bus.rs2_busy = 1'b0;
`endif
endmodule

// File: tb/tb_writeback_ctrl.sv
// tb_writeback_ctrl: directed bench for writeback_ctrl. Busy expectations follow
// the WRITEBACK_SCOREBOARD_EN build option (tied 0 when the feature is off).
module tb_writeback_ctrl;
  import writeback_pkg::*;

`ifdef WRITEBACK_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  writeback_if #(.DATA_WIDTH(32)) bus ();

  writeback_ctrl #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp_rd [4];
    logic       exp_alu [4];
    logic [4:0] ai;
    logic [4:0] mi;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.rs1_q = 5'd5; bus.rs2_q = 5'd31;
    step(); step();
    rst = 1'b0;
    step();

    // Reset then idle
    chk("rst_we",    bus.write_enable, 0);
    chk("rst_rd",    bus.rd, 0);
    chk("rst_data",  bus.rd_data, 0);
    chk("rst_busy1", bus.rs1_busy, 0);
    chk("rst_busy2", bus.rs2_busy, 0);

    // ALU only
    bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'hDEADBEEF;
    #1 chk("alu_ready", bus.alu_ready, 1);
    step();
    bus.alu_valid = 0;
    chk("alu_we",   bus.write_enable, 1);
    chk("alu_rd",   bus.rd, 3);
    chk("alu_data", bus.rd_data, 32'hDEADBEEF);
    step();
    chk("alu_we_off",   bus.write_enable, 0);
    chk("alu_rd_hold",  bus.rd, 3);
    chk("alu_dat_hold", bus.rd_data, 32'hDEADBEEF);

    // Contested: ALU favoured first, then alternation
    exp_rd  = '{5'd1, 5'd9, 5'd2, 5'd10};
    exp_alu = '{1'b1, 1'b0, 1'b1, 1'b0};
    ai = 5'd1; mi = 5'd9;
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = 1; bus.alu_rd = ai; bus.alu_data = 32'h100 + 32'(ai);
      bus.mem_valid = 1; bus.mem_rd = mi; bus.mem_data = 32'h200 + 32'(mi);
      #1;
      chk($sformatf("arb_alu_rdy%0d", k), bus.alu_ready, exp_alu[k]);
      chk($sformatf("arb_mem_rdy%0d", k), bus.mem_ready, !exp_alu[k]);
      step();
      chk($sformatf("arb_we%0d", k), bus.write_enable, 1);
      chk($sformatf("arb_rd%0d", k), bus.rd, exp_rd[k]);
      chk($sformatf("arb_data%0d", k), bus.rd_data,
          (exp_alu[k] ? 32'h100 : 32'h200) + 32'(exp_rd[k]));
      if (exp_alu[k]) ai = ai + 5'd1;
      else            mi = mi + 5'd1;
    end
    bus.alu_valid = 0; bus.mem_valid = 0;
    step();
    chk("arb_idle_we", bus.write_enable, 0);

    // rd == 0 is consumed without a write
    bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    #1 chk("x0_ready", bus.alu_ready, 1);
    step();
    bus.alu_valid = 0;
    chk("x0_we", bus.write_enable, 0);

    // Mem only
    bus.mem_valid = 1; bus.mem_rd = 5'd20; bus.mem_data = 32'hCAFE0020;
    #1 chk("mem_ready", bus.mem_ready, 1);
    step();
    bus.mem_valid = 0;
    chk("mem_we",   bus.write_enable, 1);
    chk("mem_rd",   bus.rd, 20);
    chk("mem_data", bus.rd_data, 32'hCAFE0020);
    step();

    // Scoreboard: issue rd=7 and hold busy until after commit
    bus.rs1_q = 5'd7;
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    #1 chk("sb_pre", bus.rs1_busy, 0);
    step();
    bus.issue_valid = 0;
    chk("sb_set", bus.rs1_busy, SB);
    chk("sb_other", bus.rs2_busy, 0);
    step();
    chk("sb_hold", bus.rs1_busy, SB);
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    step();
    bus.alu_valid = 0;
    chk("sb_c1_we", bus.write_enable, 1);
    chk("sb_c1_busy", bus.rs1_busy, SB);
    // Re-issue in the commit cycle: set wins over clear
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    step();
    bus.issue_valid = 0;
    chk("sb_reissue", bus.rs1_busy, SB);
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h78;
    step();
    bus.alu_valid = 0;
    chk("sb_c2_busy", bus.rs1_busy, SB);
    step();
    chk("sb_clear", bus.rs1_busy, 0);

    // Reset mid-operation: prio_mem set to 1, pending[7] set, mem in handshake
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'h55;
    bus.mem_valid = 1; bus.mem_rd = 5'd6; bus.mem_data = 32'h66;
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    step();
    bus.issue_valid = 0;
    bus.alu_valid = 0;
    #1 chk("pre_rst_mem_rdy", bus.mem_ready, 1);
    chk("pre_rst_busy", bus.rs1_busy, SB);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_valid = 0;
    chk("mid_rst_we",   bus.write_enable, 0);
    chk("mid_rst_rd",   bus.rd, 0);
    chk("mid_rst_data", bus.rd_data, 0);
    chk("mid_rst_busy", bus.rs1_busy, 0);
    bus.alu_valid = 1; bus.mem_valid = 1;
    #1;
    chk("rst_prio_alu", bus.alu_ready, 1);
    chk("rst_prio_mem", bus.mem_ready, 0);
    step();
    bus.alu_valid = 0; bus.mem_valid = 0;
    chk("post_rst_rd", bus.rd, 5);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/writeback_ctrl.md
# writeback_ctrl

Write-port driver for the integer register file. Accepts completed results from the ALU and the load unit over valid/ready handshakes and arbitrates them onto the single regfile write port (`write_enable`/`rd`/`rd_data`), one commit per cycle. A per-register pending scoreboard lets the decode stage stall on read-after-write hazards until a result has committed.

## Interface
- `DATA_WIDTH`, 32, width of result data and of `rd_data`
- `REG_COUNT`, 32, number of architectural registers; address width is `$clog2(REG_COUNT)`
- `clk` in 1, single clock, rising edge
- `rst` in 1, synchronous active-high reset (one clock; reset is synchronous and active-high)
- `alu_valid` in 1, ALU result available
- `alu_rd` in 5, ALU destination register
- `alu_data` in DATA_WIDTH, ALU result
- `alu_ready` out 1, ALU result accepted this cycle when high together with `alu_valid`
- `mem_valid` in 1, load result available
- `mem_rd` in 5, load destination register
- `mem_data` in DATA_WIDTH, load result
- `mem_ready` out 1, load result accepted this cycle when high together with `mem_valid`
- `issue_valid` in 1, decode issues an instruction that will write `issue_rd`
- `issue_rd` in 5, destination of the issued instruction
- `rs1_q`, `rs2_q` in 5, scoreboard query addresses
- `rs1_busy`, `rs2_busy` out 1, queried register has an uncommitted write (combinational)
- `write_enable` out 1, regfile write strobe (registered)
- `rd` out 5, regfile write address (registered)
- `rd_data` out DATA_WIDTH, regfile write data (registered)

## Operation
- Arbitration: `prio_mem` flop selects the winner when both sources are valid. `alu_ready = ~(mem_valid & prio_mem)`, `mem_ready = ~(alu_valid & ~prio_mem)`. If only one source is valid, it is always accepted.
- After a contested cycle (both valid), `prio_mem` flips to favour the loser. Uncontested cycles leave `prio_mem` unchanged.
- Accepted result with rd != 0: `write_enable`=1, `rd`/`rd_data` loaded next cycle.
- Accepted result with rd == 0: consumed (ready high), `write_enable`=0 next cycle, scoreboard untouched.
- No accept: `write_enable`=0 next cycle; `rd`/`rd_data` hold their previous values.
- Scoreboard: one pending bit per register; bit 0 is always 0. Bit `issue_rd` is set on `issue_valid` with issue_rd != 0. Bit `rd` is cleared at the edge that ends a cycle with `write_enable`=1.
- Set and clear of the same register at one edge: set wins.
- Decode must not issue to a register whose pending bit is set. Violating this is a protocol error and is flagged by an assertion, not handled.
- `rsN_busy = pending[rsN_q]`, including during the commit cycle itself. The regfile data is valid only in the cycle after commit, so no forwarding is provided.

## Timing
- Reset values: `write_enable`=0, `rd`=0, `rd_data`=0, all pending bits 0, `prio_mem`=0 (ALU favoured first).
- Reset mid-operation drops any in-flight commit and clears the scoreboard. Sources must re-present after reset.
- Latency: handshake at edge E produces `write_enable` high during the cycle after E, for exactly one cycle per accepted result.
- Throughput: one commit per cycle. `ready` never depends on downstream backpressure.
- Busy for a register drops one cycle after its `write_enable` cycle, which is the same edge at which the regfile stores the data.

## Configuration
- `WRITEBACK_SCOREBOARD_EN`
  - Defined: the pending-bit scoreboard and `rsN_busy` behave as described above.
  - Undefined: no pending state is built, `issue_*` inputs are ignored, and `rs1_busy`/`rs2_busy` are tied 0. The pipeline must then stall by other means.

## Structure
- Package `writeback_pkg`: `REG_COUNT`, `REG_ADDR_W`, and enum `wb_src_e` {`WB_SRC_ALU`, `WB_SRC_MEM`} for the arbitration grant.
- Sub-module `writeback_scoreboard`: pending bits, set/clear priority, query mux. It is instantiated only under `WRITEBACK_SCOREBOARD_EN`.

## Test plan
- Reset then idle: all outputs 0 and `rs1_busy`/`rs2_busy` 0 for `rs1_q`=5, `rs2_q`=31.
- ALU only, `alu_rd`=3, `alu_data`=0xDEADBEEF → `alu_ready`=1; next cycle `write_enable`=1, `rd`=3, `rd_data`=0xDEADBEEF; following cycle `write_enable`=0.
- Both valid for 4 cycles (ALU rd=1..4, mem rd=9..12 held until accepted) → commit order ALU1, MEM9, ALU2, MEM10. Mem is never starved more than one cycle.
- `alu_rd`=0 with data 0x1234 → `alu_ready`=1, `write_enable` stays 0.
- Issue rd=7 → `rs1_busy`(rs1_q=7)=1 until the edge after the commit of rd=7. Issue rd=7 in the commit cycle → busy stays 1.
- Assert `rst` while a mem result is mid-handshake and pending bit 7 is set → next cycle `write_enable`=0, busy 0, `prio_mem`=0.
